mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front end sitting directly upstream of single_port_ram.
- Accepts one byte/halfword/word request at a time from the CPU datapath (valid/ready) and drives the RAM word port.
- Performs read-modify-write for sub-word stores, since the RAM has a single full-word write enable.
- Returns load data sign/zero-extended, and flags misaligned or illegal requests.

Parameters:
- D_BITS, 32, data width; fixed at 32, four little-endian byte lanes.
- ADDR_W, 5, RAM word-address width; request byte address is ADDR_W+2 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  unit idle, request accepted when valid&&ready
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_W+2  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads when 1
- req_wdata  in  D_BITS  store data, right-aligned
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  D_BITS  load result; 0 for stores/errors
- rsp_err  out  1  misaligned or illegal size
- ram_addr  out  ADDR_W  word address (req_addr[ADDR_W+1:2])
- ram_din  out  D_BITS  write word
- ram_we  out  1  write enable
- ram_dout  in  D_BITS  RAM read data, registered one cycle after ram_addr

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset values: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_addr=0, ram_din=0, ram_we=0. req_ready=0 while rst is high.
- ram_we is forced low in any cycle rst is high.
- States: IDLE, READ, WAIT, WRITE, RESP.
- IDLE: req_ready=1. On accept, latch we/addr/size/unsigned/wdata and set ram_addr.
- Transitions from IDLE on accept:
  - error -> RESP
  - load or sub-word store -> READ
  - word store -> WRITE
- Error conditions: size 11; half with addr[0]=1; word with addr[1:0]!=0. An error produces rsp_err=1, rsp_rdata=0, and no RAM access.
- READ: RAM address presented with ram_we=0 -> WAIT.
- WAIT: ram_dout valid this cycle.
  - Load: extract lane (byte by addr[1:0], half by addr[1]), sign- or zero-extend, register into rsp_rdata -> RESP.
  - Sub-word store: merge wdata into the addressed lane(s) of ram_dout, register into ram_din -> WRITE.
- WRITE: ram_we=1 for exactly one cycle -> RESP; rsp_rdata=0.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready; on handshake -> IDLE. No overlap: next accept occurs earliest the cycle after the handshake.
- Latency, accept edge to first rsp_valid cycle:
  - error: 1
  - word store: 2
  - load: 3
  - sub-word store: 4
- Reset mid-operation: transaction dropped, no RAM write after the reset edge, no response issued.
- Address wrap: the full byte address space maps to 2^ADDR_W words; no bounds error.

Decomposition:
- Package mem_pkg:
  - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10
  - state enum (IDLE, READ, WAIT, WRITE, RESP)
  - localparam BYTE_ADDR_W=ADDR_W+2
- Sub-module mem_lane_align (combinational):
  - load_extract(word, addr[1:0], size, unsigned)
  - store_merge(old_word, wdata, addr[1:0], size)

Test Plan:
- Word store addr 0x08, wdata 0xDEADBEEF -> one-cycle ram_we with ram_addr=2, ram_din=0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0.
- Byte load addr 0x0B, signed -> rsp_rdata=0xFFFFFFDE after 3 cycles; unsigned -> 0x000000DE; ram_we never asserted.
- Half store 0x1234 at addr 0x0A -> READ of word 2, then ram_we with ram_din=0x1234BEEF; rsp 4 cycles after accept; word load of 0x08 returns 0x1234BEEF.
- Word load addr 0x06, and any request with size 11 -> rsp_err=1, rsp_rdata=0, rsp_valid 1 cycle after accept, no RAM access.
- rsp_ready held 0 for 5 cycles with second req_valid high -> rsp_valid/rsp_rdata stable, req_ready=0; second request accepted the cycle after the handshake.
- rst pulsed during WAIT of byte store to addr 0x08 -> ram_we never asserted, all outputs at reset values, subsequent word load returns the unchanged word.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store front end: request sizes, FSM states
// and the alignment rule that decides whether a request may touch the RAM.
package mem_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int BYTE_ADDR_W = ADDR_W_DEF + 2;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    RESP
  } state_e;

  function automatic logic req_error(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    req_error = 1'b0;
      SZ_H:    req_error = addr_lo[0];
      SZ_W:    req_error = (addr_lo != 2'b00);
      default: req_error = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: extracts and extends load data from a RAM word, and
// merges sub-word store data into the old word for read-modify-write.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int D_BITS = 32
) (
  input  logic [D_BITS-1:0] old_word,
  input  logic [D_BITS-1:0] wdata,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [D_BITS-1:0] load_data,
  output logic [D_BITS-1:0] merged
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    load_data = '0;
    merged    = old_word;
    lane8     = old_word[{addr_lo, 3'b000} +: 8];
    lane16    = old_word[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SZ_B: begin
        load_data = is_unsigned ? {{(D_BITS-8){1'b0}}, lane8}
                                : {{(D_BITS-8){lane8[7]}}, lane8};
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data = is_unsigned ? {{(D_BITS-16){1'b0}}, lane16}
                                : {{(D_BITS-16){lane16[15]}}, lane16};
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SZ_W: begin
        load_data = old_word;
        merged    = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for single_port_ram: one request at a time, RMW for
// sub-word stores, extended load data and alignment/size error reporting.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int D_BITS = 32,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [D_BITS-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [D_BITS-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [D_BITS-1:0] ram_din,
  output logic              ram_we,
  input  logic [D_BITS-1:0] ram_dout
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [D_BITS-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [D_BITS-1:0]   ram_din_q, ram_din_d;
  logic [D_BITS-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [D_BITS-1:0]   load_data, merged;
  logic                accept, err;

  mem_lane_align #(.D_BITS(D_BITS)) u_align (
    .old_word    (ram_dout),
    .wdata       (wdata_q),
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign err       = req_error(req_size, req_addr[1:0]);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_lo_d   = addr_lo_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: if (accept) begin
        we_d        = req_we;
        addr_lo_d   = req_addr[1:0];
        size_d      = req_size;
        uns_d       = req_unsigned;
        wdata_d     = req_wdata;
        ram_addr_d  = req_addr[ADDR_W+1:2];
        rsp_rdata_d = '0;
        rsp_err_d   = err;
        // Word stores skip the read, so the write word is ready right away.
        if (req_we && req_size == SZ_W) ram_din_d = req_wdata;
        if (err)                                 state_d = RESP;
        else if (!req_we || req_size != SZ_W)    state_d = READ;
        else                                     state_d = WRITE;
      end
      READ: state_d = WAIT;
      WAIT: begin
        if (we_q) begin
          ram_din_d = merged;
          state_d   = WRITE;
        end else begin
          rsp_rdata_d = load_data;
          state_d     = RESP;
        end
      end
      WRITE: begin
        rsp_rdata_d = '0;
        state_d     = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_lo_q   <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_lo_q   <= addr_lo_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = (state_q == WRITE) && !rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit against a byte-level memory model; a registered
// RAM model stands in for single_port_ram on the RAM port.
module tb_mem_access_unit;

  localparam int ADDR_W = 5;
  localparam int D_BITS = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [1:0]        req_size = '0;
  logic              req_unsigned = 1'b0;
  logic [D_BITS-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [D_BITS-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] ram_addr;
  logic [D_BITS-1:0] ram_din;
  logic              ram_we;
  logic [D_BITS-1:0] ram_dout;

  mem_access_unit #(.D_BITS(D_BITS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic bit ref_err(input int sz, input int a);
    return (sz == 3) || ((a % (1 << sz)) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int a, input int sz, input bit uns);
    int nb = 1 << sz;
    longint v = 0;
    for (int i = 0; i < nb; i++)
      v = v | (longint'((w >> (8 * ((a % 4) + i))) & 32'hFF) << (8 * i));
    if (!uns && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] d, input int a, input int sz);
    logic [31:0] r = w;
    for (int i = 0; i < (1 << sz); i++) r[8*((a % 4) + i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic run_txn(input bit we, input logic [6:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wdata, input int hold,
                         input string tag, output logic [31:0] rdata);
    int a = int'(addr);
    int sz = int'(size);
    int widx = a / 4;
    bit e_err = ref_err(sz, a);
    int e_lat = e_err ? 1 : (!we ? 3 : (sz == 2 ? 2 : 4));
    logic [31:0] e_rdata = (e_err || we) ? 32'h0 : ref_load(ref_mem[widx], a, sz, uns);
    logic [31:0] e_din = 32'h0;
    int e_we = (we && !e_err) ? 1 : 0;
    int lat = 0, we_cnt = 0, t = 0;
    logic [31:0] w_din = 32'h0;
    logic [4:0] w_addr = '0;
    if (we && !e_err) begin
      e_din = ref_store(ref_mem[widx], wdata, a, sz);
      ref_mem[widx] = e_din;
    end
    rdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    n_cmp++;
    if (!req_ready) begin
      $display("FAIL %s_accept: req_ready=0 after %0d cycles, required 1", tag, t);
      n_fail++; req_valid = 1'b0; return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (ram_we) begin we_cnt++; w_din = ram_din; w_addr = ram_addr; end
      if (rsp_valid) begin lat = c; break; end
    end
    rdata = rsp_rdata;
    n_cmp++;
    if (lat !== e_lat) begin
      $display("FAIL %s_latency: got %0d cycles, required %0d", tag, lat, e_lat); n_fail++;
    end
    n_cmp++;
    if (rsp_err !== e_err) begin
      $display("FAIL %s_err: got %b, required %b", tag, rsp_err, e_err); n_fail++;
    end
    n_cmp++;
    if (rsp_rdata !== e_rdata) begin
      $display("FAIL %s_rdata: got %h, required %h", tag, rsp_rdata, e_rdata); n_fail++;
    end
    n_cmp++;
    if (we_cnt !== e_we) begin
      $display("FAIL %s_we_count: got %0d, required %0d", tag, we_cnt, e_we); n_fail++;
    end
    if (e_we == 1) begin
      n_cmp++;
      if (w_addr !== addr[6:2] || w_din !== e_din) begin
        $display("FAIL %s_write: got addr %0d din %h, required addr %0d din %h",
                 tag, w_addr, w_din, addr[6:2], e_din); n_fail++;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e_rdata || rsp_err !== e_err || req_ready !== 1'b0 || ram_we !== 1'b0) begin
        $display("FAIL %s_hold: got valid %b rdata %h err %b ready %b we %b, required 1 %h %b 0 0",
                 tag, rsp_valid, rsp_rdata, rsp_err, req_ready, ram_we, e_rdata, e_err); n_fail++;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL %s_release: got valid %b ready %b, required 0 1", tag, rsp_valid, req_ready); n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
        ram_addr !== 5'd0 || ram_din !== 32'h0 || ram_we !== 1'b0) begin
      $display("FAIL reset_values: got ready %b valid %b rdata %h err %b addr %0d din %h we %b, required all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_din, ram_we); n_fail++;
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [31:0] r;
    for (int i = 0; i < (1 << ADDR_W); i++)
      run_txn(1'b1, 7'(i * 4), 2'b10, 1'b0, $urandom, 0, "fill", r);
  endtask

  task automatic test_word_store();
    logic [31:0] r;
    run_txn(1'b1, 7'h08, 2'b10, 1'b0, 32'hDEADBEEF, 0, "word_store", r);
  endtask

  task automatic test_byte_load();
    logic [31:0] r;
    run_txn(1'b0, 7'h0B, 2'b00, 1'b0, 32'h0, 0, "byte_load_s", r);
    n_cmp++;
    if (r !== 32'hFFFFFFDE) begin
      $display("FAIL byte_load_s_const: got %h, required ffffffde", r); n_fail++;
    end
    run_txn(1'b0, 7'h0B, 2'b00, 1'b1, 32'h0, 0, "byte_load_u", r);
    n_cmp++;
    if (r !== 32'h000000DE) begin
      $display("FAIL byte_load_u_const: got %h, required 000000de", r); n_fail++;
    end
  endtask

  task automatic test_half_store();
    logic [31:0] r;
    run_txn(1'b1, 7'h0A, 2'b01, 1'b0, 32'h00001234, 0, "half_store", r);
    run_txn(1'b0, 7'h08, 2'b10, 1'b0, 32'h0, 0, "half_readback", r);
    n_cmp++;
    if (r !== 32'h1234BEEF) begin
      $display("FAIL half_readback_const: got %h, required 1234beef", r); n_fail++;
    end
  endtask

  task automatic test_errors();
    logic [31:0] r;
    run_txn(1'b0, 7'h06, 2'b10, 1'b0, 32'h0, 0, "err_word_misalign", r);
    run_txn(1'b1, 7'h05, 2'b01, 1'b0, 32'hFFFF, 1, "err_half_misalign", r);
    run_txn(1'b0, 7'h00, 2'b11, 1'b0, 32'h0, 0, "err_size_ld", r);
    run_txn(1'b1, 7'h10, 2'b11, 1'b0, 32'h12345678, 0, "err_size_st", r);
  endtask

  task automatic test_back_to_back();
    logic [31:0] e_a = ref_load(ref_mem[2], 8, 2, 1'b0);
    logic [31:0] e_b = ref_load(ref_mem[2], 9, 0, 1'b1);
    logic [31:0] held;
    int lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h08; req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 7'h09; req_size = 2'b00; req_unsigned = 1'b1;
    for (int c = 0; c < 10 && !rsp_valid; c++) @(negedge clk);
    held = rsp_rdata;
    n_cmp++;
    if (rsp_valid !== 1'b1 || held !== e_a) begin
      $display("FAIL b2b_first: got valid %b rdata %h, required 1 %h", rsp_valid, held, e_a); n_fail++;
    end
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e_a || req_ready !== 1'b0) begin
        $display("FAIL b2b_stall: got valid %b rdata %h ready %b, required 1 %h 0",
                 rsp_valid, rsp_rdata, req_ready, e_a); n_fail++;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      $display("FAIL b2b_gap: got ready %b valid %b, required 1 0", req_ready, rsp_valid); n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      $display("FAIL b2b_second_accept: got ready %b, required 0", req_ready); n_fail++;
    end
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (rsp_valid) begin lat = c; break; end
    end
    n_cmp++;
    if (lat !== 3 || rsp_rdata !== e_b) begin
      $display("FAIL b2b_second: got lat %0d rdata %h, required 3 %h", lat, rsp_rdata, e_b); n_fail++;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int we_seen = 0, valid_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h08; req_size = 2'b00; req_wdata = 32'h000000AA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (ram_we) we_seen++;
    @(negedge clk);
    if (ram_we) we_seen++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
        ram_addr !== 5'd0 || ram_din !== 32'h0 || ram_we !== 1'b0) begin
      $display("FAIL midreset_values: got ready %b valid %b rdata %h err %b addr %0d din %h we %b, required all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_din, ram_we); n_fail++;
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ram_we) we_seen++;
      if (rsp_valid) valid_seen++;
    end
    n_cmp++;
    if (we_seen !== 0 || valid_seen !== 0) begin
      $display("FAIL midreset_quiet: got we %0d valid %0d cycles, required 0 0", we_seen, valid_seen); n_fail++;
    end
    run_txn(1'b0, 7'h08, 2'b10, 1'b0, 32'h0, 0, "midreset_readback", r);
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 80; i++)
      run_txn(1'($urandom), 7'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
              $urandom, int'($urandom_range(0, 2)), "random", r);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_word_store();
    test_byte_load();
    test_half_store();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
